// File: rtl/entrada_dispositivos_pkg.sv
// Shared types for the board I/O controllers: FSM encoding, channel count, data slice width.
// Also provides the round-robin picker used to choose the next device to serve.
package entrada_dispositivos_pkg;

  localparam int N_DEV_PKG = 4;
  localparam int DEV_W     = 2;
  localparam int SLICE_W   = 32;
  localparam int SW_W      = 18;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_WAIT_RELEASE = 2'd2,
    ST_DONE         = 2'd3
  } estado_t;

  // First requesting device at or after (last + 1), wrapping; returns last if none request.
  function automatic logic [DEV_W-1:0] rr_pick(input logic [N_DEV_PKG-1:0] req,
                                               input logic [DEV_W-1:0]     last);
    logic [DEV_W-1:0] idx;
    logic [DEV_W-1:0] pick;
    logic             found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= N_DEV_PKG; i++) begin
      idx = last + DEV_W'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/entrada_dispositivos_debounce.sv
// Two-flop synchronizer plus debouncer for an active-low push-button; level starts released (1).
// Level and one-cycle press/release pulses are registered, appearing DEBOUNCE_CYCLES+2 edges after a stable change.
module debounce_botao #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic level,
  output logic press,
  output logic release_evt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a      <= 1'b1;
      sync_b      <= 1'b1;
      level       <= 1'b1;
      cnt         <= '0;
      press       <= 1'b0;
      release_evt <= 1'b0;
    end else begin
      sync_a      <= button;
      sync_b      <= sync_a;
      press       <= 1'b0;
      release_evt <= 1'b0;
      // Any cycle where the input agrees with the accepted level restarts the count.
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level       <= sync_b;
        cnt         <= '0;
        press       <= ~sync_b;
        release_evt <= sync_b;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/entrada_dispositivos.sv
// Serves per-device input requests round-robin: waits for a debounced press, captures switches, completes on release.
// done_in pulses 2 cycles after the release event; requests are level-held by the processor until done_in.
module entrada_dispositivos
  import entrada_dispositivos_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int N_DEV           = N_DEV_PKG
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_DEV-1:0]           req_in,
  input  logic [SW_W-1:0]            switches,
  input  logic                       enter,
  output logic [N_DEV*SLICE_W-1:0]   din_out,
  output logic [N_DEV-1:0]           done_in,
  output logic                       busy,
  output logic [DEV_W-1:0]           dev_sel
);

  estado_t          state;
  logic [DEV_W-1:0] last_srv;
  logic             btn_level;
  logic             btn_press;
  logic             btn_release;

  debounce_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_botao (
    .clk        (clk),
    .rst_n      (rst_n),
    .button     (enter),
    .level      (btn_level),
    .press      (btn_press),
    .release_evt(btn_release)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      din_out  <= '0;
      done_in  <= '0;
      busy     <= 1'b0;
      dev_sel  <= '0;
      last_srv <= DEV_W'(N_DEV - 1);
    end else begin
      done_in <= '0;
      case (state)
        ST_IDLE: begin
          // A button still held from before must be released first, so only a fresh press captures.
          if ((|req_in) && btn_level) begin
            dev_sel <= rr_pick(req_in, last_srv);
            state   <= ST_WAIT_PRESS;
            busy    <= 1'b1;
          end
        end
        ST_WAIT_PRESS: begin
          if (!req_in[dev_sel]) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (btn_press) begin
            din_out[dev_sel*SLICE_W +: SLICE_W] <= SLICE_W'(switches);
            state <= ST_WAIT_RELEASE;
          end
        end
        ST_WAIT_RELEASE: begin
          if (btn_release) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_in[dev_sel] <= 1'b1;
          last_srv         <= dev_sel;
          state            <= ST_IDLE;
          busy             <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_entrada_dispositivos.sv
// Directed bench for entrada_dispositivos with a short debounce window.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_entrada_dispositivos;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_in;
  logic [17:0]  switches;
  logic         enter;
  logic [127:0] din_out;
  logic [3:0]   done_in;
  logic         busy;
  logic [1:0]   dev_sel;

  int n_checks = 0;
  int n_fail   = 0;

  entrada_dispositivos #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_in  (req_in),
    .switches(switches),
    .enter   (enter),
    .din_out (din_out),
    .done_in (done_in),
    .busy    (busy),
    .dev_sel (dev_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Steps n cycles and reports whether done_in was ever nonzero.
  task automatic step_watch_done(input int n, output logic seen);
    seen = 1'b0;
    repeat (n) begin
      step(1);
      if (done_in != 4'b0) seen = 1'b1;
    end
  endtask

  logic seen;

  initial begin
    rst_n    = 1'b0;
    req_in   = 4'b0;
    switches = 18'h0;
    enter    = 1'b1;
    step(2);
    chk("reset_din", din_out, 128'h0);
    chk("reset_done", {124'h0, done_in}, 128'h0);
    chk("reset_busy", {127'h0, busy}, 128'h0);
    chk("reset_devsel", {126'h0, dev_sel}, 128'h0);
    rst_n = 1'b1;
    step(1);

    // Single clean transaction on device 0
    req_in   = 4'b0001;
    switches = 18'h0002A;
    step(1);
    chk("t1_busy", {127'h0, busy}, 128'h1);
    chk("t1_devsel", {126'h0, dev_sel}, 128'h0);
    enter = 1'b0;
    step(6);
    chk("t1_no_early_capture", din_out, 128'h0);
    step(1);
    chk("t1_capture", din_out, 128'h2A);
    enter = 1'b1;
    step_watch_done(7, seen);
    chk("t1_no_early_done", {127'h0, seen}, 128'h0);
    step(1);
    chk("t1_done", {124'h0, done_in}, 128'h1);
    chk("t1_din_full", din_out, 128'h0000002A);
    req_in = 4'b0000;
    step(1);
    chk("t1_done_one_cycle", {124'h0, done_in}, 128'h0);
    chk("t1_idle_busy", {127'h0, busy}, 128'h0);

    // Round-robin over all four devices from reset
    rst_n = 1'b0;
    step(2);
    rst_n  = 1'b1;
    req_in = 4'b1111;
    step(1);
    chk("t2_first_dev", {126'h0, dev_sel}, 128'h0);
    for (int i = 0; i < 4; i++) begin
      switches = 18'(i + 1);
      enter    = 1'b0;
      step(7);
      enter = 1'b1;
      step(8);
      chk("t2_done", {124'h0, done_in}, 128'(4'b0001 << i));
      if (i == 3) req_in = 4'b0000;
      step(1);
      if (i < 3) chk("t2_next_dev", {126'h0, dev_sel}, 128'(i + 1));
    end
    chk("t2_din", din_out, 128'h00000004_00000003_00000002_00000001);
    chk("t2_idle", {127'h0, busy}, 128'h0);

    // Bouncing press: 3 low / 1 high for 20 cycles, then stable low
    req_in = 4'b0001;
    step(1);
    switches = 18'h3FFFF;
    for (int c = 0; c < 20; c++) begin
      enter = ((c % 4) == 3) ? 1'b1 : 1'b0;
      step(1);
    end
    chk("t3_no_bounce_capture", din_out, 128'h00000004_00000003_00000002_00000001);
    chk("t3_still_waiting", {127'h0, busy}, 128'h1);
    switches = 18'h00155;
    enter    = 1'b0;
    step(7);
    chk("t3_capture", din_out, 128'h00000004_00000003_00000002_00000155);
    enter = 1'b1;
    step(8);
    chk("t3_done", {124'h0, done_in}, 128'h1);
    req_in = 4'b0000;
    step(1);

    // Request withdrawn in WAIT_PRESS
    req_in = 4'b0100;
    step(1);
    chk("t4_devsel", {126'h0, dev_sel}, 128'h2);
    chk("t4_busy", {127'h0, busy}, 128'h1);
    req_in = 4'b0000;
    step(1);
    chk("t4_abort_busy", {127'h0, busy}, 128'h0);
    chk("t4_abort_done", {124'h0, done_in}, 128'h0);
    chk("t4_devsel_hold", {126'h0, dev_sel}, 128'h2);
    chk("t4_din_hold", din_out, 128'h00000004_00000003_00000002_00000155);
    req_in = 4'b0001;
    step(1);
    chk("t4_dev0_next", {126'h0, dev_sel}, 128'h0);
    req_in = 4'b0000;
    step(1);
    // Pointer still at device 0, so device 2 outranks device 0
    req_in = 4'b0101;
    step(1);
    chk("t4_pointer_kept", {126'h0, dev_sel}, 128'h2);
    // Press event and request drop land on the same edge
    switches = 18'h01111;
    enter    = 1'b0;
    step(6);
    req_in = 4'b0000;
    step(1);
    chk("t4_abort_wins_busy", {127'h0, busy}, 128'h0);
    enter = 1'b1;
    step_watch_done(8, seen);
    chk("t4_abort_wins_done", {127'h0, seen}, 128'h0);
    chk("t4_abort_wins_din", din_out, 128'h00000004_00000003_00000002_00000155);

    // Reset during WAIT_RELEASE
    req_in   = 4'b0001;
    step(1);
    switches = 18'h00ABC;
    enter    = 1'b0;
    step(7);
    chk("t5_capture", din_out, 128'h00000004_00000003_00000002_00000ABC);
    enter = 1'b1;
    step(3);
    rst_n = 1'b0;
    #1;
    chk("t5_async_din", din_out, 128'h0);
    chk("t5_async_busy", {127'h0, busy}, 128'h0);
    chk("t5_async_devsel", {126'h0, dev_sel}, 128'h0);
    chk("t5_async_done", {124'h0, done_in}, 128'h0);
    step(2);
    rst_n  = 1'b1;
    req_in = 4'b0000;
    step_watch_done(12, seen);
    chk("t5_no_done_after_reset", {127'h0, seen}, 128'h0);
    chk("t5_busy_after_reset", {127'h0, busy}, 128'h0);

    // Button already held when the request arrives
    enter = 1'b0;
    step(10);
    req_in = 4'b0010;
    step(3);
    chk("t6_held_idle", {127'h0, busy}, 128'h0);
    enter = 1'b1;
    step(6);
    chk("t6_before_release", {127'h0, busy}, 128'h0);
    step(1);
    chk("t6_after_release", {127'h0, busy}, 128'h1);
    chk("t6_devsel", {126'h0, dev_sel}, 128'h1);
    chk("t6_no_capture_yet", din_out, 128'h0);
    switches = 18'h3FFFF;
    enter    = 1'b0;
    step(7);
    chk("t6_capture", din_out, 128'h00000000_00000000_0003FFFF_00000000);
    enter = 1'b1;
    step(8);
    chk("t6_done", {124'h0, done_in}, 128'h2);
    req_in = 4'b0000;
    step(1);
    chk("t6_done_cleared", {124'h0, done_in}, 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/entrada_dispositivos.md
ENTRADA_DISPOSITIVOS -- requirements
Module: entrada_dispositivos

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, number of consecutive stable clk cycles needed to accept a button level change (1 ms at 50 MHz).
REQ-002 Parameter N_DEV, default 4, number of input-device channels served; fixed at 4 in this revision.
REQ-003 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port req_in  input  4  per-device input request from the processor, level, held high until the matching done_in pulse.
REQ-006 Port switches  input  18  raw board switch value to be captured as input data.
REQ-007 Port enter  input  1  raw push-button, active-low (0 = pressed), asynchronous to clk.
REQ-008 Port din_out  output  128  captured data, device d in bits [32d+31:32d], switch value zero-extended to 32 bits.
REQ-009 Port done_in  output  4  per-device completion, one-cycle high pulse.
REQ-010 Port busy  output  1  high while a request is being served (any state other than IDLE).
REQ-011 Port dev_sel  output  2  index of the device currently served; holds last value in IDLE.

Function
REQ-012 Button path: two-flop synchronizer, then debouncer; debounced level changes only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-013 Press event = debounced level 1->0 transition, pulse of one cycle; release event = 0->1 transition, one cycle.
REQ-014 FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE, DONE.
REQ-015 IDLE: if req_in nonzero, select device by round-robin starting at (last served + 1) mod 4, latch into dev_sel, go WAIT_PRESS next cycle.
REQ-016 IDLE entry into WAIT_PRESS also requires debounced button released; if held, stay in IDLE until released.
REQ-017 WAIT_PRESS: on press event, capture switches into din_out slice of dev_sel in that same edge, go WAIT_RELEASE.
REQ-018 WAIT_PRESS: if req_in[dev_sel] drops, go IDLE; no capture, no done, last-served pointer unchanged.
REQ-019 WAIT_RELEASE: on release event go DONE; req_in changes ignored in this state.
REQ-020 DONE: done_in[dev_sel] high for exactly this one cycle, last-served pointer := dev_sel, next state IDLE.
REQ-021 Earliest done_in is 2 cycles after release event; new service earliest 1 cycle after DONE.
REQ-022 Press and req drop in same cycle in WAIT_PRESS: abort wins, no capture.
REQ-023 din_out slices not being written hold their value indefinitely; only the served slice updates.
REQ-024 Press events in IDLE, WAIT_RELEASE or DONE are ignored.
REQ-025 At most one done_in bit high in any cycle.

Reset
REQ-026 rst_n low asynchronously forces: state IDLE, din_out 0, done_in 0, busy 0, dev_sel 0, last-served pointer 3 (so device 0 has first priority), synchronizer flops and debounced level 1 (released), debounce counter 0.
REQ-027 Reset mid-transaction discards it: no done_in pulse, no partial capture on release of reset.
REQ-028 Outputs are registered; none combinationally depends on req_in, switches or enter.

Structure
REQ-029 State encoding, N_DEV and the 32-bit slice width live in a shared package used also by the output-display controller.
REQ-030 Synchronizer plus debouncer is one sub-module, debounce_botao (ports clk, rst_n, button, level, press, release), reusable by other board inputs.
REQ-031 Arbitration, FSM and capture registers reside in entrada_dispositivos itself.

Verification (DEBOUNCE_CYCLES = 4)
REQ-032 req_in=0001, switches=18'h0002A, clean press then release -> din_out[31:0]=32'h2A, done_in=0001 one cycle, 2 cycles after release event, other slices 0.
REQ-033 req_in=1111 held, four press/release cycles with switches 1,2,3,4 -> served order 0,1,2,3, din_out=128'h00000004_00000003_00000002_00000001.
REQ-034 Press bouncing 3 cycles low/1 high repeatedly for 20 cycles, then stable low -> exactly one press event, one capture.
REQ-035 req_in=0100 in WAIT_PRESS, drop to 0000 -> IDLE, busy 0, no done_in, din_out unchanged; then req_in=0001 -> device 0 served next.
REQ-036 rst_n pulsed low during WAIT_RELEASE -> all outputs 0 immediately, no done_in after reset release.
REQ-037 Button held pressed when req_in=0010 rises -> stays IDLE until release, then WAIT_PRESS; capture only on next fresh press.
